// File: rtl/dfr_phase_sequencer.sv
// dfr_phase_sequencer
// Run sequencer for the DFR core. One start pulse steps the reservoir through
// reset, warm-up (INIT) and history capture, then hands off to the matrix
// multiplier. Supports INIT/multiply skip modes, abort, per-sample indexing and
// a sticky address-overflow flag. Every output is decoded from registered
// state or counters, so no input reaches an output combinationally.

module dfr_phase_sequencer #(
  parameter int CNT_WIDTH   = 16,
  parameter int NUM_OUTPUTS = 4
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [CNT_WIDTH-1:0] num_init_steps,
  input  logic [CNT_WIDTH-1:0] num_steps_per_sample,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic                 mm_busy,
  output logic                 busy,
  output logic                 done,
  output logic                 reservoir_en,
  output logic                 reservoir_rst,
  output logic                 history_en,
  output logic [CNT_WIDTH-1:0] input_addr,
  output logic [CNT_WIDTH-1:0] history_addr,
  output logic [CNT_WIDTH-1:0] sample_idx,
  output logic                 mm_start,
  output logic                 mm_rst,
  output logic [CNT_WIDTH-1:0] mm_rows,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_INIT, S_CAPTURE, S_MM_START, S_MM_WAIT, S_DONE, S_ABORT
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_post_init;

  // Run configuration, frozen on the start cycle
  logic [CNT_WIDTH-1:0] r_n;
  logic [CNT_WIDTH-1:0] r_p;
  logic [CNT_WIDTH-1:0] r_s;
  logic [1:0]           r_mode;

  // Progress counters
  logic [CNT_WIDTH-1:0] r_init_cnt;
  logic [CNT_WIDTH-1:0] r_step;
  logic [CNT_WIDTH-1:0] r_sample_idx;
  logic [CNT_WIDTH-1:0] r_input_addr;
  logic [CNT_WIDTH-1:0] r_history_addr;
  logic                 r_overflow;
  logic                 r_seen;

  logic w_cap_ok;
  logic w_init_last;
  logic w_step_last;
  logic w_cap_last;

  // A zero-length capture (P or S zero) is skipped entirely.
  assign w_cap_ok    = (r_p != '0) && (r_s != '0);
  assign w_init_last = (r_init_cnt == r_n - ONE);
  assign w_step_last = (r_step == r_p - ONE);
  assign w_cap_last  = w_step_last && (r_sample_idx == r_s - ONE);
  assign w_post_init = w_cap_ok ? S_CAPTURE : (r_mode[1] ? S_DONE : S_MM_START);

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  // Next-state logic; abort overrides every transition outside IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_RST;
      S_RST:      w_next = (!r_mode[0] && (r_n != '0)) ? S_INIT : w_post_init;
      S_INIT:     if (w_init_last) w_next = w_post_init;
      S_CAPTURE:  if (w_cap_last) w_next = r_mode[1] ? S_DONE : S_MM_START;
      S_MM_START: w_next = S_MM_WAIT;
      S_MM_WAIT:  if (!mm_busy && r_seen) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      S_ABORT:    w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_ABORT;
  end

  // Output decode from registered state and counters only
  always_comb begin
    busy          = (r_state != S_IDLE);
    done          = (r_state == S_DONE);
    reservoir_en  = (r_state == S_INIT) || (r_state == S_CAPTURE);
    reservoir_rst = (r_state == S_RST)  || (r_state == S_ABORT);
    mm_rst        = (r_state == S_RST)  || (r_state == S_ABORT);
    history_en    = (r_state == S_CAPTURE);
    mm_start      = (r_state == S_MM_START);
    input_addr    = r_input_addr;
    history_addr  = r_history_addr;
    sample_idx    = r_sample_idx;
    overflow      = r_overflow;
    mm_rows       = CNT_WIDTH'(NUM_OUTPUTS);
  end

  // Config latch, address/step counters, overflow and multiplier-seen flag.
  // Addresses advance at the edge ending each enabled cycle, so the first
  // enabled cycle presents address 0. Counters hold after the run ends.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_n            <= '0;
      r_p            <= '0;
      r_s            <= '0;
      r_mode         <= '0;
      r_init_cnt     <= '0;
      r_step         <= '0;
      r_sample_idx   <= '0;
      r_input_addr   <= '0;
      r_history_addr <= '0;
      r_overflow     <= 1'b0;
      r_seen         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n            <= num_init_steps;
            r_p            <= num_steps_per_sample;
            r_s            <= num_samples;
            r_mode         <= mode;
            r_init_cnt     <= '0;
            r_step         <= '0;
            r_sample_idx   <= '0;
            r_input_addr   <= '0;
            r_history_addr <= '0;
            r_overflow     <= 1'b0;
            r_seen         <= 1'b0;
          end
        end
        S_INIT: begin
          r_init_cnt   <= r_init_cnt + ONE;
          r_input_addr <= r_input_addr + ONE;
          if (&r_input_addr) r_overflow <= 1'b1;
        end
        S_CAPTURE: begin
          r_input_addr   <= r_input_addr + ONE;
          r_history_addr <= r_history_addr + ONE;
          if ((&r_input_addr) || (&r_history_addr)) r_overflow <= 1'b1;
          // sample_idx stays at S-1 after the final step
          if (w_step_last) begin
            r_step <= '0;
            if (!w_cap_last) r_sample_idx <= r_sample_idx + ONE;
          end else begin
            r_step <= r_step + ONE;
          end
        end
        S_MM_START: r_seen <= 1'b0;
        S_MM_WAIT:  if (mm_busy) r_seen <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Directed bench for dfr_phase_sequencer: a per-cycle vector table for a full
// skip-multiply run (with mid-run input disturbance), then hand-written
// sequences for multiplier handshake, skip modes, abort, overflow and reset.

module tb_dfr_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default widths
  logic        rst_n, start, abort, mm_busy;
  logic [1:0]  mode;
  logic [15:0] n_in, p_in, s_in;
  logic        busy, done, ren, rrst, hen, mms, mmr, ovf;
  logic [15:0] ia, ha, si, rows;

  // Instance 2: narrow counters for wrap testing
  logic        rst2_n, start2, abort2, mm_busy2;
  logic [1:0]  mode2;
  logic [3:0]  n2, p2, s2;
  logic        busy2, done2, ren2, rrst2, hen2, mms2, mmr2, ovf2;
  logic [3:0]  ia2, ha2, si2, rows2;

  dfr_phase_sequencer #(.CNT_WIDTH(16), .NUM_OUTPUTS(4)) u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
    .mode(mode), .num_init_steps(n_in), .num_steps_per_sample(p_in),
    .num_samples(s_in), .mm_busy(mm_busy), .busy(busy), .done(done),
    .reservoir_en(ren), .reservoir_rst(rrst), .history_en(hen),
    .input_addr(ia), .history_addr(ha), .sample_idx(si), .mm_start(mms),
    .mm_rst(mmr), .mm_rows(rows), .overflow(ovf));

  dfr_phase_sequencer #(.CNT_WIDTH(4), .NUM_OUTPUTS(3)) u_dut4 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst2_n), .start(start2), .abort(abort2),
    .mode(mode2), .num_init_steps(n2), .num_steps_per_sample(p2),
    .num_samples(s2), .mm_busy(mm_busy2), .busy(busy2), .done(done2),
    .reservoir_en(ren2), .reservoir_rst(rrst2), .history_en(hen2),
    .input_addr(ia2), .history_addr(ha2), .sample_idx(si2), .mm_start(mms2),
    .mm_rst(mmr2), .mm_rows(rows2), .overflow(ovf2));

  typedef struct packed {
    logic start; logic abort; logic [1:0] mode; logic mm_busy;
    logic [15:0] n; logic [15:0] p; logic [15:0] s;
  } in_t;
  typedef struct packed {
    logic busy; logic done; logic ren; logic rrst;
    logic hen; logic mms; logic mmr; logic ovf;
    logic [15:0] ia; logic [15:0] ha; logic [15:0] si;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic out_t pack1();
    return '{busy, done, ren, rrst, hen, mms, mmr, ovf, ia, ha, si};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic in_t mki(input logic st, input logic [1:0] md,
                              input logic [15:0] n, input logic [15:0] p, input logic [15:0] s);
    return '{st, 1'b0, md, 1'b0, n, p, s};
  endfunction

  // Expected: busy,done,ren,rrst,hen,mms,mmr,ovf packed as 8 bits, then addrs
  function automatic out_t mko(input logic [7:0] f, input logic [15:0] a,
                               input logic [15:0] h, input logic [15:0] x);
    return '{f[7], f[6], f[5], f[4], f[3], f[2], f[1], f[0], a, h, x};
  endfunction

  logic bad;

  initial begin
    rst_n = 0; start = 0; abort = 0; mm_busy = 0; mode = 0; n_in = 0; p_in = 0; s_in = 0;
    rst2_n = 0; start2 = 0; abort2 = 0; mm_busy2 = 0; mode2 = 0; n2 = 0; p2 = 0; s2 = 0;

    // Run N=3 P=4 S=2 mode=2; after start, inputs are disturbed (mode=1,
    // N=7 P=1 S=9, start re-pulsed) to prove config is latched.
    // Entry k drives cycle Tk and expects outputs in T(k+1).
    tbl.push_back('{mki(1, 2'd2, 3, 4, 2), mko(8'b1001_0010, 0, 0, 0)});   // T1 RST
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_0000, 0, 0, 0)});   // T2 INIT
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_0000, 1, 0, 0)});
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_0000, 2, 0, 0)});
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_1000, 3, 0, 0)});   // T5 CAPTURE
    tbl.push_back('{mki(1, 2'd1, 7, 1, 9), mko(8'b1010_1000, 4, 1, 0)});
    tbl.push_back('{mki(1, 2'd1, 7, 1, 9), mko(8'b1010_1000, 5, 2, 0)});
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_1000, 6, 3, 0)});
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_1000, 7, 4, 1)});
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_1000, 8, 5, 1)});
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_1000, 9, 6, 1)});
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1010_1000, 10, 7, 1)});  // T12
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b1100_0000, 11, 8, 1)});  // T13 DONE
    tbl.push_back('{mki(0, 2'd1, 7, 1, 9), mko(8'b0000_0000, 11, 8, 1)});  // T14 IDLE

    #2;
    chk("reset_outputs", 64'(pack1()), 64'd0);
    chk("reset_mm_rows", 64'(rows), 64'd4);
    chk("reset_outputs_w4", 64'({busy2, done2, ren2, rrst2, hen2, mms2, mmr2, ovf2, ia2, ha2, si2}), 64'd0);
    chk("mm_rows_w4", 64'(rows2), 64'd3);
    tick(); tick();
    rst_n = 1; rst2_n = 1;
    tick();

    for (int k = 0; k < tbl.size(); k++) begin
      start = tbl[k].i.start; abort = tbl[k].i.abort; mode = tbl[k].i.mode;
      mm_busy = tbl[k].i.mm_busy; n_in = tbl[k].i.n; p_in = tbl[k].i.p; s_in = tbl[k].i.s;
      tick();
      chk($sformatf("vec%0d", k), 64'(pack1()), 64'(tbl[k].o));
    end

    // Multiplier handshake: mm_busy high T14..T18, done at T20
    start = 1; mode = 2'd0; n_in = 3; p_in = 4; s_in = 2;
    tick(); start = 0;
    repeat (12) tick();
    chk("mm_start_pulse", 64'({mms, busy}), 64'b11);
    tick();
    chk("mm_start_single", 64'({mms, done, busy}), 64'b001);
    mm_busy = 1;
    bad = 0;
    repeat (5) begin tick(); if (done) bad = 1; end
    mm_busy = 0;
    chk("no_early_done", 64'({bad, done, busy}), 64'b001);
    tick();
    chk("done_after_busy_falls", 64'(done), 64'd1);
    tick();
    chk("idle_after_done", 64'({done, busy}), 64'd0);

    // Skip INIT: capture starts at input_addr 0
    start = 1; mode = 2'd1; n_in = 3; p_in = 2; s_in = 2;
    tick(); start = 0;
    chk("skipinit_rst", 64'({rrst, mmr, ren}), 64'b110);
    tick();
    chk("skipinit_capture0", 64'({ren, hen, ia, ha}), {30'd0, 1'b1, 1'b1, 16'd0, 16'd0});
    repeat (3) tick();
    chk("skipinit_capture_end", 64'({ia, ha, si}), {16'd0, 16'd3, 16'd3, 16'd1});
    tick();
    chk("skipinit_mm_start", 64'({mms, ren}), 64'b10);
    tick(); mm_busy = 1;
    tick(); mm_busy = 0;
    tick();
    chk("skipinit_done", 64'(done), 64'd1);
    tick();

    // S=0: RST goes straight to MM_START; abort in MM_WAIT
    start = 1; s_in = 0;
    tick(); start = 0;
    tick();
    chk("s0_mm_start", 64'({mms, ren, hen}), 64'b100);
    tick(); abort = 1;
    tick(); abort = 0;
    chk("abort_mmwait", 64'({busy, done, rrst, mmr}), 64'b1011);
    tick();
    chk("abort_to_idle", 64'({busy, rrst, mmr}), 64'd0);

    // Abort at capture step 5 (T10)
    start = 1; mode = 2'd2; n_in = 3; p_in = 4; s_in = 2;
    tick(); start = 0;
    repeat (9) tick();
    chk("capture_step5", 64'({hen, ha}), {47'd0, 1'b1, 16'd5});
    abort = 1;
    tick(); abort = 0;
    chk("abort_state", 64'({busy, done, ren, rrst, hen, mmr}), 64'b100101);
    tick();
    chk("abort_idle", 64'({busy, rrst, mmr}), 64'd0);
    bad = 0;
    repeat (3) begin tick(); if (done || busy) bad = 1; end
    chk("abort_no_done", 64'(bad), 64'd0);
    abort = 1;
    tick(); abort = 0;
    chk("abort_in_idle_ignored", 64'({busy, rrst, mmr}), 64'd0);

    // Narrow counters: input_addr wraps 15->0 at end of T17
    start2 = 1; mode2 = 2'd2; n2 = 10; p2 = 4; s2 = 2;
    tick(); start2 = 0;
    repeat (16) tick();
    chk("wrap_before", 64'({ovf2, ia2}), {59'd0, 1'b0, 4'd15});
    tick();
    chk("wrap_after", 64'({ovf2, ia2}), {59'd0, 1'b1, 4'd0});
    tick(); tick();
    chk("wrap_done", 64'({done2, ovf2, ha2}), {58'd0, 2'b11, 4'd8});
    tick();
    chk("ovf_sticky_idle", 64'({busy2, ovf2}), 64'b01);
    start2 = 1;
    tick(); start2 = 0;
    chk("ovf_cleared_on_start", 64'({ovf2, ia2, busy2}), 64'b1);

    // Asynchronous reset mid-INIT
    tick(); tick();
    chk("init_before_reset", 64'({ren2, ia2}), {59'd0, 1'b1, 4'd1});
    #2 rst2_n = 0;
    #1;
    chk("async_reset_outputs", 64'({busy2, done2, ren2, rrst2, hen2, mms2, mmr2, ovf2, ia2, ha2, si2}), 64'd0);
    rst2_n = 1;
    tick();
    chk("after_reset_idle", 64'({busy2, done2}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dfr_phase_sequencer.md
# dfr_phase_sequencer

Parametrised run sequencer for the DFR core: the next generation of the core's fixed-size controller. From one start pulse it steps the reservoir through three phases: reset, initialisation (warm-up) and history capture. It then hands off to the matrix multiplier for an arbitrary number of output rows. It drives the reservoir enable, the input/history memory address counters and the multiplier start/reset. It adds phase-skip modes, abort, per-sample indexing and a sticky address-overflow flag. It sits between the AXI config registers and the reservoir/RAM/multiplier datapath.

## Interface
- CNT_WIDTH, 16, width of step, sample and address counters.
- NUM_OUTPUTS, 4, multiplier row count; driven on mm_rows, 1..2^CNT_WIDTH-1.
- S_AXI_ACLK  in  1  sole clock, rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low; all state returns to IDLE.
- start  in  1  run request, sampled only in IDLE.
- abort  in  1  synchronous cancel, any state.
- mode  in  2  bit0 skip INIT, bit1 skip multiply; sampled with start.
- num_init_steps  in  CNT_WIDTH  warm-up steps (N).
- num_steps_per_sample  in  CNT_WIDTH  virtual-node steps per sample (P).
- num_samples  in  CNT_WIDTH  samples to capture (S).
- mm_busy  in  1  multiplier busy.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on normal completion.
- reservoir_en  out  1  high in INIT and CAPTURE.
- reservoir_rst  out  1  high in RST and ABORT.
- history_en  out  1  history RAM write enable, high in CAPTURE.
- input_addr  out  CNT_WIDTH  input RAM read address.
- history_addr  out  CNT_WIDTH  history RAM write address.
- sample_idx  out  CNT_WIDTH  current capture sample index.
- mm_start  out  1  one-cycle multiplier start pulse.
- mm_rst  out  1  high in RST and ABORT.
- mm_rows  out  CNT_WIDTH  constant NUM_OUTPUTS.
- overflow  out  1  sticky; set if any address counter wraps in a run.

## Operation
- States: IDLE, RST, INIT, CAPTURE, MM_START, MM_WAIT, DONE, ABORT.
- Configuration: N, P, S and mode are latched on the start cycle. Mid-run input changes have no effect.
- IDLE: on start, go to RST. Clear input_addr, history_addr, sample_idx and the step counter. Clear overflow.
- RST: one cycle.
  - Go to INIT if mode[0]=0 and N>0.
  - Otherwise go to CAPTURE if P>0 and S>0.
  - Otherwise go to MM_START, or to DONE if mode[1]=1.
- INIT: exactly N cycles. input_addr increments each cycle. history_en stays low. Exit to CAPTURE or its skip target, as for RST.
- CAPTURE: exactly P*S cycles.
  - input_addr continues from its INIT value.
  - history_addr increments each cycle.
  - The step counter wraps at P; each wrap increments sample_idx.
  - Exit after the last step, with sample_idx==S-1 and step==P-1.
- MM_START: mm_start high for one cycle, then MM_WAIT.
- MM_WAIT: set an internal seen flag when mm_busy=1. Go to DONE on the first cycle with mm_busy=0 and the seen flag set.
- DONE: done high for one cycle, then IDLE. The counter outputs hold their final values until the next start.
- abort: has priority over every transition in non-IDLE states. The next state is ABORT (one cycle), then IDLE; done stays low. abort in IDLE is ignored.
- start: ignored while busy.
- overflow: set when input_addr or history_addr increments from all-ones. The counter wraps to 0 and the run continues.

## Timing
- Reset values: state IDLE; all counters 0; every output 0 except mm_rows.
- All outputs are decoded from registered state or counters. There is no combinational path from any input to any output.
- With start high in cycle 0 (T0):
  - RST occupies T1.
  - INIT occupies T2..T1+N.
  - CAPTURE follows immediately for P*S cycles.
- input_addr and history_addr hold the address for the current cycle. The first enabled cycle uses address 0 and the value increments at the clock edge ending each enabled cycle.
- Run length with skip multiply: done is asserted at T(2+N+P*S).
- Asynchronous reset mid-run: outputs drop immediately; no done pulse.

## Test plan
- N=3, P=4, S=2, mode=2 →
  - reservoir_en high for 11 cycles (T2..T12);
  - history_en high for 8 cycles with history_addr 0..7;
  - input_addr 0..10;
  - sample_idx 0 then 1;
  - done at T13.
- Same configuration, mode=0, mm_busy high 5 cycles starting 1 cycle after mm_start → done exactly 1 cycle after mm_busy falls; mm_start is a single pulse.
- mode=1, N=3 → no INIT cycles; the CAPTURE input_addr starts at 0; S=0 skips straight to MM_START.
- abort during CAPTURE step 5 → ABORT next cycle with reservoir_rst and mm_rst high for 1 cycle, then IDLE; done never asserted.
- start re-pulsed while busy, and inputs changed mid-run → run unaffected and counts match the latched values.
- CNT_WIDTH=4, N=10, P=4, S=2 → input_addr wraps past 15, overflow goes and stays high; it clears on the next start. Also assert S_AXI_ARESETN low mid-INIT → all outputs 0 immediately.
